// File: rtl/ps2_scan_fifo_if.sv
// Bus between the CPU-side poller / PS/2 pads and the scan-code receiver.
interface ps2_scan_fifo_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic        rd;
    logic [31:0] rdata;
    logic        ready;
    logic        overflow;
    logic        frame_err;

    // Device side: consumes pad lines and read strobe, drives status/data.
    modport slave (
        input  ps2_clk,
        input  ps2_data,
        input  rd,
        output rdata,
        output ready,
        output overflow,
        output frame_err
    );

    // Host side: drives pad lines and read strobe, observes status/data.
    modport master (
        output ps2_clk,
        output ps2_data,
        output rd,
        input  rdata,
        input  ready,
        input  overflow,
        input  frame_err
    );
endinterface

// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard receiver feeding a scan-code FIFO, polled by CPU loads.
// Read word: {ready, 22'b0, overflow, head[7:0]}; each strobed read pops one entry.
module ps2_scan_fifo #(
    parameter int unsigned DEPTH_LOG2     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input logic            clk,
    input logic            reset,
    ps2_scan_fifo_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StCheck
    } state_t;

    // Synchronisers and edge detector
    logic r_sclk_meta;
    logic r_sclk;
    logic r_sclk_prev;
    logic r_sdata_meta;
    logic r_sdata;
    logic w_fall;

    // Two-flop synchronisers for both pad lines plus the previous clock sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sclk_meta  <= 1'b1;
            r_sclk       <= 1'b1;
            r_sclk_prev  <= 1'b1;
            r_sdata_meta <= 1'b1;
            r_sdata      <= 1'b1;
        end else begin
            r_sclk_meta  <= bus.ps2_clk;
            r_sclk       <= r_sclk_meta;
            r_sclk_prev  <= r_sclk;
            r_sdata_meta <= bus.ps2_data;
            r_sdata      <= r_sdata_meta;
        end
    end

    assign w_fall = r_sclk_prev & ~r_sclk;

    // Inactivity timer
    logic [CNT_W-1:0] r_idle_cnt;
    logic             w_timeout;

    // Counts cycles since the last PS/2 falling edge, saturating at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= '0;
        end else if (w_fall) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != TIMEOUT_VAL) begin
            r_idle_cnt <= r_idle_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_idle_cnt == TIMEOUT_VAL);

    // Receiver
    state_t     r_state;
    logic [3:0] r_bitcnt;
    logic [9:0] r_shift;      // after bit 10: [7:0] data, [8] parity, [9] stop
    logic       r_good;
    logic       r_frame_err;
    logic [9:0] w_shift_next;

    assign w_shift_next = {r_sdata, r_shift[9:1]};

    // Frame FSM: start bit, 8 data bits, parity, stop, then a one-cycle verdict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_bitcnt    <= 4'd0;
            r_shift     <= '0;
            r_good      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // A high line on a falling edge is noise, not a frame.
                    if (w_fall && !r_sdata) begin
                        r_state  <= StRecv;
                        r_bitcnt <= 4'd1;
                        r_shift  <= '0;
                    end
                end
                StRecv: begin
                    if (w_fall) begin
                        r_shift <= w_shift_next;
                        if (r_bitcnt == 4'd10) begin
                            r_state     <= StCheck;
                            r_bitcnt    <= 4'd0;
                            r_good      <= (^w_shift_next[8:0]) & w_shift_next[9];
                            r_frame_err <= ~((^w_shift_next[8:0]) & w_shift_next[9]);
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end else if (w_timeout) begin
                        // Keyboard stalled mid-frame: drop the partial byte.
                        r_state     <= StIdle;
                        r_bitcnt    <= 4'd0;
                        r_shift     <= '0;
                        r_frame_err <= 1'b1;
                    end
                end
                StCheck: begin
                    r_state  <= StIdle;
                    r_bitcnt <= 4'd0;
                    r_good   <= 1'b0;
                end
                default: begin
                    r_state  <= StIdle;
                    r_bitcnt <= 4'd0;
                end
            endcase
        end
    end

    // Scan-code FIFO
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic             r_overflow;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_write;
    logic [7:0]       w_head;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[DEPTH_LOG2] != r_rptr[DEPTH_LOG2]) &&
                     (r_wptr[DEPTH_LOG2-1:0] == r_rptr[DEPTH_LOG2-1:0]);
    assign w_push  = (r_state == StCheck) && r_good;
    assign w_pop   = bus.rd & ~w_empty;
    // A same-cycle pop frees the slot the push lands in, so full is no obstacle.
    assign w_write = w_push & (~w_full | w_pop);

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wptr[DEPTH_LOG2-1:0]] <= r_shift[7:0];
        end
    end

    // Pointers and the sticky overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_overflow <= 1'b0;
            end else if (w_push && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Read word is combinational so a single-cycle load sees the current head.
    always_comb begin
        w_head = 8'h00;
        if (!w_empty) begin
            w_head = r_mem[r_rptr[DEPTH_LOG2-1:0]];
        end
    end

    assign bus.rdata     = {~w_empty, 22'b0, r_overflow, w_head};
    assign bus.ready     = ~w_empty;
    assign bus.overflow  = r_overflow;
    assign bus.frame_err = r_frame_err;

endmodule
